alex_spi_loader: RTL and testbench

ALEX_SPI_LOADER -- requirements
Module: alex_spi_loader

---
 rtl/alex_spi_loader_if.sv | 20 ++
 rtl/alex_spi_loader.sv | 142 ++++++++++++++
 tb/tb_alex_spi_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alex_spi_loader_if.sv
// Alex filter-board loader bus: C&C parser request side plus the serial/strobe outputs.
interface alex_spi_loader_if;
  logic [47:0] Alex_data;
  logic        Alex_data_ready;
  logic        SPI_data;
  logic        SPI_clock;
  logic        Tx_load_strobe;
  logic        Rx_load_strobe;
  logic        Rx1_load_strobe;
  logic        busy;

  modport master (
    output Alex_data, Alex_data_ready,
    input  SPI_data, SPI_clock, Tx_load_strobe, Rx_load_strobe, Rx1_load_strobe, busy
  );
  modport slave (
    input  Alex_data, Alex_data_ready,
    output SPI_data, SPI_clock, Tx_load_strobe, Rx_load_strobe, Rx1_load_strobe, busy
  );
endinterface

// File: rtl/alex_spi_loader.sv
// Serialises the 48-bit Alex filter word as 16-bit SPI words (Tx, Rx0[, Rx1]) with latch strobes.
// Optional macro ALEX_RX1_WORD_EN adds the Rx1 word [47:32] as a third word with its own strobe.
module alex_spi_loader #(
  parameter int CLK_DIV        = 16,
  parameter int SEND_ON_CHANGE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  alex_spi_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, STROBE, GAP} state_t;

`ifdef ALEX_RX1_WORD_EN
  localparam logic [1:0]  LAST_WORD = 2'd2;
  localparam logic [47:0] CMP_MASK  = {48{1'b1}};
`else
  localparam logic [1:0]  LAST_WORD = 2'd1;
  localparam logic [47:0] CMP_MASK  = {16'h0000, {32{1'b1}}};
`endif
  localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
  localparam logic [8:0] FULL_END = 9'(2 * CLK_DIV - 1);

  state_t      r_state;
  logic        r_rdy_q, r_pend;
  logic [47:0] r_shadow, r_last;
  logic [8:0]  r_cnt;
  logic [3:0]  r_bit;
  logic [1:0]  r_word;
  logic        r_spi_data, r_spi_clk, r_tx_stb, r_rx_stb, r_busy;
`ifdef ALEX_RX1_WORD_EN
  logic        r_rx1_stb;
`endif
  logic        w_edge, w_same;
  logic [15:0] w_word;

  assign w_edge = bus.Alex_data_ready & ~r_rdy_q;
  assign w_same = (SEND_ON_CHANGE != 0) && (((r_shadow ^ r_last) & CMP_MASK) == 48'h0);

  // Word order on the wire: Tx, Rx0, then Rx1.
  always_comb begin
    w_word = r_shadow[31:16];
    if (r_word == 2'd1)      w_word = r_shadow[15:0];
    else if (r_word == 2'd2) w_word = r_shadow[47:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rdy_q    <= 1'b0;
      r_pend     <= 1'b0;
      r_shadow   <= 48'h0;
      r_last     <= {48{1'b1}};
      r_cnt      <= 9'd0;
      r_bit      <= 4'd0;
      r_word     <= 2'd0;
      r_spi_data <= 1'b0;
      r_spi_clk  <= 1'b0;
      r_tx_stb   <= 1'b0;
      r_rx_stb   <= 1'b0;
`ifdef ALEX_RX1_WORD_EN
      r_rx1_stb  <= 1'b0;
`endif
      r_busy     <= 1'b0;
    end else begin
      r_rdy_q <= bus.Alex_data_ready;
      if (w_edge && r_state != IDLE) r_pend <= 1'b1;
      case (r_state)
        IDLE: if (w_edge || r_pend) begin
          r_shadow <= bus.Alex_data;
          r_busy   <= 1'b1;
          r_word   <= 2'd0;
          r_pend   <= 1'b0;
          r_state  <= LOAD;
        end
        LOAD: if (r_word == 2'd0 && w_same) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_spi_data <= w_word[15];
          r_bit      <= 4'd15;
          r_cnt      <= 9'd0;
          r_state    <= SHIFT_LOW;
        end
        SHIFT_LOW: if (r_cnt == HALF_END) begin
          r_cnt     <= 9'd0;
          r_spi_clk <= 1'b1;
          r_state   <= SHIFT_HIGH;
        end else r_cnt <= r_cnt + 9'd1;
        SHIFT_HIGH: if (r_cnt == HALF_END) begin
          r_cnt     <= 9'd0;
          r_spi_clk <= 1'b0;
          if (r_bit == 4'd0) begin
            r_spi_data <= 1'b0;
            r_tx_stb   <= (r_word == 2'd0);
            r_rx_stb   <= (r_word == 2'd1);
`ifdef ALEX_RX1_WORD_EN
            r_rx1_stb  <= (r_word == 2'd2);
`endif
            r_state    <= STROBE;
          end else begin
            r_bit      <= r_bit - 4'd1;
            r_spi_data <= w_word[r_bit - 4'd1];
            r_state    <= SHIFT_LOW;
          end
        end else r_cnt <= r_cnt + 9'd1;
        STROBE: if (r_cnt == FULL_END) begin
          r_cnt    <= 9'd0;
          r_tx_stb <= 1'b0;
          r_rx_stb <= 1'b0;
`ifdef ALEX_RX1_WORD_EN
          r_rx1_stb <= 1'b0;
`endif
          r_state  <= GAP;
        end else r_cnt <= r_cnt + 9'd1;
        // last_sent only moves once the whole frame is out; an aborted frame leaves it alone.
        GAP: if (r_cnt == FULL_END) begin
          r_cnt <= 9'd0;
          if (r_word == LAST_WORD) begin
            r_last  <= r_shadow;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_word  <= r_word + 2'd1;
            r_state <= LOAD;
          end
        end else r_cnt <= r_cnt + 9'd1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SPI_data       = r_spi_data;
  assign bus.SPI_clock      = r_spi_clk;
  assign bus.Tx_load_strobe = r_tx_stb;
  assign bus.Rx_load_strobe = r_rx_stb;
  assign bus.busy           = r_busy;
`ifdef ALEX_RX1_WORD_EN
  assign bus.Rx1_load_strobe = r_rx1_stb;
`else
  assign bus.Rx1_load_strobe = 1'b0;
`endif
endmodule

// File: tb/tb_alex_spi_loader.sv
// Bench: two loaders (send-on-change on/off) fed identical requests; a serial monitor decodes
// words at each strobe and checks them against a queue of expected {strobe, word} records.
module tb_alex_spi_loader;
  localparam int C = 2;
`ifdef ALEX_RX1_WORD_EN
  localparam int W = 3;
  localparam bit RX1_ONLY_SENDS = 1'b1;
`else
  localparam int W = 2;
  localparam bit RX1_ONLY_SENDS = 1'b0;
`endif
  localparam int FRAME = W * (1 + 36 * C);

  typedef struct {
    logic [47:0] data;
    int          hold;
    logic        send0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alex_spi_loader_if bus0();
  alex_spi_loader_if bus1();

  alex_spi_loader #(.CLK_DIV(C), .SEND_ON_CHANGE(1)) dut0 (.clock(clk), .reset_n(rst_n), .bus(bus0));
  alex_spi_loader #(.CLK_DIV(C), .SEND_ON_CHANGE(0)) dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1));

  int n_vec = 0;
  int n_bad = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic        prev_sck[2];
  logic        prev_stb[2];
  logic [15:0] sh[2];
  int nb[2], slen[2], busy_cnt[2], nclk[2], exp_busy[2], exp_clk[2];

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic sck, input logic sd, input logic bsy,
                     input logic [2:0] stb);
    logic [1:0]  kind;
    logic [17:0] e;
    if (!rst_n) begin
      prev_sck[id] = 1'b0;
      prev_stb[id] = 1'b0;
      nb[id]       = 0;
      slen[id]     = 0;
    end else begin
      if (bsy) busy_cnt[id]++;
      if (sck && !prev_sck[id]) begin
        sh[id] = {sh[id][14:0], sd};
        nb[id]++;
        nclk[id]++;
      end
      if (stb != 3'b000) begin
        chk("strobe_serial_idle", id, int'({sck, sd}), 0);
        if (!prev_stb[id]) begin
          slen[id] = 0;
          kind = (stb == 3'b001) ? 2'd0 : (stb == 3'b010) ? 2'd1 : (stb == 3'b100) ? 2'd2 : 2'd3;
          chk("strobe_bits", id, nb[id], 16);
          if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_strobe dut%0d: got kind %0d word 0x%h, expected none",
                     id, kind, sh[id]);
          end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk("frame_word", id, int'({kind, sh[id]}), int'(e));
          end
          nb[id] = 0;
        end
        slen[id]++;
      end else if (prev_stb[id]) begin
        chk("strobe_len", id, slen[id], 2 * C);
      end
      prev_stb[id] = (stb != 3'b000);
      prev_sck[id] = sck;
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.SPI_clock, bus0.SPI_data, bus0.busy,
        {bus0.Rx1_load_strobe, bus0.Rx_load_strobe, bus0.Tx_load_strobe});
    mon(1, bus1.SPI_clock, bus1.SPI_data, bus1.busy,
        {bus1.Rx1_load_strobe, bus1.Rx_load_strobe, bus1.Tx_load_strobe});
  end

  task automatic push_rec(input int id, input logic [17:0] r);
    if (id == 0) q0.push_back(r);
    else         q1.push_back(r);
  endtask

  task automatic expect_frame(input int id, input logic [47:0] d);
    push_rec(id, {2'd0, d[31:16]});
    push_rec(id, {2'd1, d[15:0]});
    if (W == 3) push_rec(id, {2'd2, d[47:32]});
    exp_busy[id] += FRAME;
    exp_clk[id]  += 16 * W;
  endtask

  task automatic expect_skip(input int id);
    exp_busy[id] += 1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; nclk[i] = 0; exp_busy[i] = 0; exp_clk[i] = 0;
    end
  endtask

  task automatic check_counts();
    for (int i = 0; i < 2; i++) begin
      chk("busy_cycles", i, busy_cnt[i], exp_busy[i]);
      chk("sck_edges", i, nclk[i], exp_clk[i]);
    end
  endtask

  task automatic pulse(input logic [47:0] d, input int hold);
    @(posedge clk); #1;
    bus0.Alex_data = d;  bus1.Alex_data = d;
    bus0.Alex_data_ready = 1'b1; bus1.Alex_data_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus0.Alex_data_ready = 1'b0; bus1.Alex_data_ready = 1'b0;
  endtask

  // Busy drops for one cycle between a frame and its pending follow-up, so require a quiet run.
  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (!bus0.busy && !bus1.busy) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", 0, int'(n >= 3000), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    logic [47:0] x;
    int n;
    tbl[0] = '{48'h0000_0000_0000, 1,   1'b1};
    tbl[1] = '{48'h0000_A5A5_3C3C, 1,   1'b1};
    tbl[2] = '{48'h0000_A5A5_3C3C, 1,   1'b0};
    tbl[3] = '{48'h1234_A5A5_3C3C, 1,   RX1_ONLY_SENDS};
    tbl[4] = '{48'h0000_FFFF_0001, 100, 1'b1};
    tbl[5] = '{48'h0000_FFFF_0001, 100, 1'b0};
    tbl[6] = '{48'hBEEF_0001_0002, 3,   1'b1};

    bus0.Alex_data = '0; bus1.Alex_data = '0;
    bus0.Alex_data_ready = 1'b0; bus1.Alex_data_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, int'(bus0.busy), 0);
    chk("rst_sck", 0, int'(bus0.SPI_clock), 0);
    chk("rst_sdata", 0, int'(bus0.SPI_data), 0);
    chk("rst_strobes", 0, int'({bus0.Tx_load_strobe, bus0.Rx_load_strobe, bus0.Rx1_load_strobe}), 0);
    chk("rst_busy", 1, int'(bus1.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      clr();
      if (tbl[i].send0) expect_frame(0, tbl[i].data);
      else              expect_skip(0);
      expect_frame(1, tbl[i].data);
      pulse(tbl[i].data, tbl[i].hold);
      wait_idle();
      check_counts();
    end

    // Latency, then three requests during a frame collapse into one follow-up frame.
    clr();
    expect_frame(0, 48'h0000_AAAA_5555); expect_frame(1, 48'h0000_AAAA_5555);
    @(posedge clk); #1;
    bus0.Alex_data = 48'h0000_AAAA_5555; bus1.Alex_data = 48'h0000_AAAA_5555;
    bus0.Alex_data_ready = 1'b1; bus1.Alex_data_ready = 1'b1;
    @(negedge clk);
    chk("lat_busy_pre", 0, int'(bus0.busy), 0);
    @(posedge clk); #1;
    bus0.Alex_data_ready = 1'b0; bus1.Alex_data_ready = 1'b0;
    @(negedge clk);
    chk("lat_busy", 0, int'(bus0.busy), 1);
    @(negedge clk);
    chk("lat_first_bit", 0, int'({bus0.SPI_data, bus0.SPI_clock}), 2);
    repeat (20) @(posedge clk);
    pulse(48'h0000_AAAA_5555, 1);
    repeat (10) @(posedge clk);
    pulse(48'h0000_AAAA_5555, 1);
    repeat (10) @(posedge clk);
    pulse(48'h0000_1111_2222, 1);
    expect_frame(0, 48'h0000_1111_2222); expect_frame(1, 48'h0000_1111_2222);
    wait_idle();
    check_counts();

    // Reset during the 9th Tx bit aborts silently; the same request then sends in full.
    x = 48'h0000_C3C3_0F0F;
    clr();
    pulse(x, 1);
    n = 0;
    while (nclk[0] < 8 && n < 1000) begin @(negedge clk); n++; end
    chk("abort_wait_timeout", 0, int'(n >= 1000), 0);
    repeat (C + 1) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 0, int'({bus0.busy, bus0.SPI_clock, bus0.SPI_data, bus0.Tx_load_strobe}), 0);
    chk("abort_outputs", 1, int'({bus1.busy, bus1.SPI_clock, bus1.SPI_data, bus1.Tx_load_strobe}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    expect_frame(0, x); expect_frame(1, x);
    pulse(x, 1);
    wait_idle();
    check_counts();

    chk("leftover_words", 0, q0.size(), 0);
    chk("leftover_words", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
